final2_soc_sysid_checker: RTL and testbench



---
 rtl/final2_soc_sysid_checker.sv | 212 +++++++++++++++++++++
 tb/tb_final2_soc_sysid_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/final2_soc_sysid_checker.sv
// final2_soc_sysid_checker
//
// Avalon-MM read master placed directly behind the system ID slave. A start
// pulse reads the ID word (address 0), retrying a bounded number of times while
// the slave may still be coming out of reset. It then reads the timestamp word
// (address 1). Both words are compared against build-time constants, and the
// design publishes sticky pass/fail flags and the captured words.
//
// Build option: define SYSID_CHECK_TS_EN to enable the timestamp read. When it
// is undefined, only the ID is checked, ts_ok is tied to 1, ts_value is tied to
// 0 and avm_address is tied to 0.
module final2_soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h5A1E_2B1F,
  parameter int unsigned READ_LATENCY = 0,   // 0..3
  parameter int unsigned RETRY_LIMIT  = 3    // 0..15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

`ifdef SYSID_CHECK_TS_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    FIN     = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    FIN     = 3'd5
  } state_e;
`endif

  // The strobe cycle already accounts for one latency cycle. The wait state
  // therefore counts the L-1 remaining cycles and captures when it reaches 0.
  // This makes the capture edge fall at 1+L after the accepting edge.
  localparam bit         ZERO_LAT   = (READ_LATENCY == 0);
  localparam logic [1:0] LAT_LOAD   = ZERO_LAT ? 2'd0 : 2'(READ_LATENCY - 1);
  localparam logic [3:0] RETRY_LOAD = 4'(RETRY_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  retry_q, retry_d;
  logic [1:0]  lat_q, lat_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic [31:0] id_value_q, id_value_d;
  logic        id_cap;

`ifdef SYSID_CHECK_TS_EN
  logic        addr_q, addr_d;
  logic        ts_ok_q, ts_ok_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        ts_cap;
`endif

  // Next-state, counter and result logic.
  always_comb begin
    // NOTE: every variable gets a default before the case statement. Paths that
    // do not assign a variable then hold its value explicitly, so no latch is
    // inferred.
    state_d    = state_q;
    retry_d    = retry_q;
    lat_d      = lat_q;
    done_d     = done_q;
    id_ok_d    = id_ok_q;
    id_value_d = id_value_q;
    id_cap     = 1'b0;
`ifdef SYSID_CHECK_TS_EN
    addr_d     = addr_q;
    ts_ok_d    = ts_ok_q;
    ts_value_d = ts_value_q;
    ts_cap     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_ID;
          done_d  = 1'b0;
          id_ok_d = 1'b0;
          retry_d = RETRY_LOAD;
`ifdef SYSID_CHECK_TS_EN
          ts_ok_d = 1'b0;
          addr_d  = 1'b0;
`endif
        end
      end
      RD_ID: begin
        lat_d = LAT_LOAD;
        if (ZERO_LAT) id_cap = 1'b1;
        else          state_d = WAIT_ID;
      end
      WAIT_ID: begin
        if (lat_q == 2'd0) id_cap = 1'b1;
        else               lat_d = lat_q - 2'd1;
      end
`ifdef SYSID_CHECK_TS_EN
      RD_TS: begin
        lat_d = LAT_LOAD;
        if (ZERO_LAT) ts_cap = 1'b1;
        else          state_d = WAIT_TS;
      end
      WAIT_TS: begin
        if (lat_q == 2'd0) ts_cap = 1'b1;
        else               lat_d = lat_q - 2'd1;
      end
`endif
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ID capture decides between the timestamp read, a retry and giving up.
    if (id_cap) begin
      id_value_d = avm_readdata;
      if (avm_readdata == EXPECTED_ID) begin
        id_ok_d = 1'b1;
`ifdef SYSID_CHECK_TS_EN
        state_d = RD_TS;
        addr_d  = 1'b1;
`else
        state_d = FIN;
`endif
      end else if (retry_q != 4'd0) begin
        retry_d = retry_q - 4'd1;
        state_d = RD_ID;
      end else begin
        id_ok_d = 1'b0;
        state_d = FIN;
      end
    end

`ifdef SYSID_CHECK_TS_EN
    // Timestamp capture has no retry; the result is final.
    if (ts_cap) begin
      ts_value_d = avm_readdata;
      ts_ok_d    = (avm_readdata == EXPECTED_TS);
      state_d    = FIN;
    end
`endif
  end

  // State and result registers; reset abandons any check in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      retry_q    <= 4'd0;
      lat_q      <= 2'd0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      id_value_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // the same pre-edge values, regardless of statement order.
      state_q    <= state_d;
      retry_q    <= retry_d;
      lat_q      <= lat_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      id_value_q <= id_value_d;
    end
  end

`ifdef SYSID_CHECK_TS_EN
  // Timestamp-path registers; the address holds between strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= 1'b0;
      ts_ok_q    <= 1'b0;
      ts_value_q <= 32'd0;
    end else begin
      addr_q     <= addr_d;
      ts_ok_q    <= ts_ok_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign ts_ok       = ts_ok_q;
  assign ts_value    = ts_value_q;
`else
  assign avm_address = 1'b0;
  assign avm_read    = (state_q == RD_ID);
  assign ts_ok       = 1'b1;
  assign ts_value    = 32'd0;
`endif

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign id_ok    = id_ok_q;
  assign id_value = id_value_q;

endmodule

// File: tb/tb_final2_soc_sysid_checker.sv
// Bench for final2_soc_sysid_checker.
// Two instances share clock and reset: index 0 uses READ_LATENCY=0 and
// index 1 uses READ_LATENCY=2, both with RETRY_LIMIT=3. A small slave model
// returns a bad ID for the first `bad_reads` ID reads of each check and a
// programmable timestamp. Expected values are written for both builds
// (SYSID_CHECK_TS_EN defined or undefined).
module tb_final2_soc_sysid_checker;

`ifdef SYSID_CHECK_TS_EN
  localparam bit T = 1'b1;
`else
  localparam bit T = 1'b0;
`endif

  localparam logic [31:0] GOOD_TS = 32'h5A1E_2B1F;
  localparam logic [31:0] BAD_TS  = 32'h1234_5678;
  localparam logic [31:0] BAD_ID  = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start    [2];
  logic        addr     [2];
  logic        rd       [2];
  logic        busy     [2];
  logic        done     [2];
  logic        id_ok    [2];
  logic        ts_ok    [2];
  logic [31:0] rdata    [2];
  logic [31:0] id_value [2];
  logic [31:0] ts_value [2];

  final2_soc_sysid_checker #(.READ_LATENCY(0), .RETRY_LIMIT(3)) u_l0 (
    .clock(clock), .reset(reset), .start(start[0]),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_readdata(rdata[0]),
    .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
    .id_value(id_value[0]), .ts_value(ts_value[0])
  );

  final2_soc_sysid_checker #(.READ_LATENCY(2), .RETRY_LIMIT(3)) u_l2 (
    .clock(clock), .reset(reset), .start(start[1]),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_readdata(rdata[1]),
    .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
    .id_value(id_value[1]), .ts_value(ts_value[1])
  );

  // Slave model
  int          bad_reads = 0;
  logic [31:0] ts_resp   = GOOD_TS;
  int          id_reads [2] = '{0, 0};
  int          ts_reads [2] = '{0, 0};
  int          id_base  [2] = '{0, 0};

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (rd[k]) begin
        if (addr[k]) ts_reads[k] <= ts_reads[k] + 1;
        else         id_reads[k] <= id_reads[k] + 1;
      end
    end
  end

  // The ID read in progress (1-based within the current check) selects the data.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      int cur;
      cur = id_reads[k] - id_base[k] + ((rd[k] && !addr[k]) ? 1 : 0);
      if (addr[k]) rdata[k] = ts_resp;
      else         rdata[k] = (cur <= bad_reads) ? BAD_ID : 32'h0000_0000;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          k;
    int          bad;
    logic [31:0] ts;
    bit          poke;      // pulse start again at edge 2 (while busy)
    int          exp_done;  // edge at which done rises, start sampled at edge 0
    int          exp_idr;
    int          exp_tsr;
    logic        exp_id_ok;
    logic        exp_ts_ok;
    logic [31:0] exp_idv;
    logic [31:0] exp_tsv;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int i, input vec_t v);
    int n;
    int got;
    int idr0;
    int tsr0;
    bit overlap;
    bad_reads    = v.bad;
    ts_resp      = v.ts;
    id_base[v.k] = id_reads[v.k];
    idr0         = id_reads[v.k];
    tsr0         = ts_reads[v.k];
    start[v.k]   = 1'b1;
    @(negedge clock);                       // after edge 0
    start[v.k]   = 1'b0;
    check($sformatf("v%0d busy_after_start", i), busy[v.k], 1'b1);
    check($sformatf("v%0d done_cleared", i), done[v.k], 1'b0);
    check($sformatf("v%0d id_ok_cleared", i), id_ok[v.k], 1'b0);
    check($sformatf("v%0d ts_ok_cleared", i), ts_ok[v.k], T ? 1'b0 : 1'b1);
    n = 0;
    got = -1;
    overlap = 1'b0;
    while (got < 0 && n < 60) begin
      n++;
      start[v.k] = (v.poke && n == 2);
      @(negedge clock);                     // after edge n
      if (busy[v.k] && done[v.k]) overlap = 1'b1;
      if (done[v.k]) got = n;
    end
    start[v.k] = 1'b0;
    check($sformatf("v%0d done_edge", i), got, v.exp_done);
    check($sformatf("v%0d id_reads", i), id_reads[v.k] - idr0, v.exp_idr);
    check($sformatf("v%0d ts_reads", i), ts_reads[v.k] - tsr0, v.exp_tsr);
    check($sformatf("v%0d id_ok", i), id_ok[v.k], v.exp_id_ok);
    check($sformatf("v%0d ts_ok", i), ts_ok[v.k], v.exp_ts_ok);
    check($sformatf("v%0d id_value", i), id_value[v.k], v.exp_idv);
    check($sformatf("v%0d ts_value", i), ts_value[v.k], v.exp_tsv);
    check($sformatf("v%0d busy_done_overlap", i), overlap, 1'b0);
  endtask

  initial begin
    int r0;
    int r1;
    start[0] = 1'b0;
    start[1] = 1'b0;

    //            k bad ts       poke done       idr tsr       idok tsok          idv     tsv
    vecs[0] = '{0, 0,  GOOD_TS, 0, T ? 3 : 2,   1, T ? 1 : 0, 1'b1, 1'b1,         32'h0,  T ? GOOD_TS : 32'h0};
    vecs[1] = '{1, 2,  GOOD_TS, 1, T ? 13 : 10, 3, T ? 1 : 0, 1'b1, 1'b1,         32'h0,  T ? GOOD_TS : 32'h0};
    vecs[2] = '{0, 99, GOOD_TS, 0, 5,           4, 0,         1'b0, T ? 1'b0 : 1'b1, BAD_ID, T ? GOOD_TS : 32'h0};
    vecs[3] = '{0, 0,  BAD_TS,  0, T ? 3 : 2,   1, T ? 1 : 0, 1'b1, T ? 1'b0 : 1'b1, 32'h0,  T ? BAD_TS : 32'h0};
    vecs[4] = '{0, 3,  GOOD_TS, 0, T ? 6 : 5,   4, T ? 1 : 0, 1'b1, 1'b1,         32'h0,  T ? GOOD_TS : 32'h0};
    vecs[5] = '{1, 99, BAD_TS,  1, 13,          4, 0,         1'b0, T ? 1'b0 : 1'b1, BAD_ID, T ? GOOD_TS : 32'h0};
    vecs[6] = '{1, 0,  BAD_TS,  0, T ? 7 : 4,   1, T ? 1 : 0, 1'b1, T ? 1'b0 : 1'b1, 32'h0,  T ? BAD_TS : 32'h0};

    // Reset state, then 20 idle cycles with no reads.
    repeat (2) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d busy", k), busy[k], 1'b0);
      check($sformatf("rst%0d done", k), done[k], 1'b0);
      check($sformatf("rst%0d read", k), rd[k], 1'b0);
    end
    reset = 1'b0;
    r0 = id_reads[0] + ts_reads[0];
    r1 = id_reads[1] + ts_reads[1];
    repeat (20) @(negedge clock);
    check("idle reads l0", id_reads[0] + ts_reads[0] - r0, 0);
    check("idle reads l2", id_reads[1] + ts_reads[1] - r1, 0);
    check("idle busy", busy[0], 1'b0);
    check("idle done", done[0], 1'b0);
    check("idle id_ok", id_ok[0], 1'b0);
    check("idle ts_ok", ts_ok[0], T ? 1'b0 : 1'b1);
    check("idle id_value", id_value[0], 32'h0);
    check("idle ts_value", ts_value[0], 32'h0);
    check("idle address", addr[0], 1'b0);

    // Table-driven checks. Each start follows the previous done immediately,
    // so it lands in the first IDLE cycle after FIN.
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // done stays set while idle.
    repeat (3) @(negedge clock);
    check("sticky done", done[1], 1'b1);

    // Reset during WAIT_TS (WAIT_ID when the timestamp read is not built).
    bad_reads    = 0;
    ts_resp      = GOOD_TS;
    id_base[1]   = id_reads[1];
    start[1]     = 1'b1;
    @(negedge clock);                       // after edge 0
    start[1]     = 1'b0;
    repeat (T ? 4 : 1) @(negedge clock);
    check("pre-reset busy", busy[1], 1'b1);
    check("pre-reset id_ok", id_ok[1], T ? 1'b1 : 1'b0);
    reset = 1'b1;
    #1;
    check("midrst busy", busy[1], 1'b0);
    check("midrst done", done[1], 1'b0);
    check("midrst id_ok", id_ok[1], 1'b0);
    check("midrst ts_ok", ts_ok[1], T ? 1'b0 : 1'b1);
    check("midrst id_value", id_value[1], 32'h0);
    check("midrst ts_value", ts_value[1], 32'h0);
    check("midrst address", addr[1], 1'b0);
    check("midrst read", rd[1], 1'b0);
    @(negedge clock);
    reset = 1'b0;
    r1 = id_reads[1] + ts_reads[1];
    repeat (10) @(negedge clock);
    check("post-reset reads", id_reads[1] + ts_reads[1] - r1, 0);
    check("post-reset busy", busy[1], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
